// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: default sizes, requester
// indices and the width of the debug outputs.
package wb_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // Requester slots, lowest index first in the packed request buses.
  localparam int WB_CP0  = 0;  // mfc0
  localparam int WB_MUL  = 1;  // mul / mfhi / mflo
  localparam int WB_LOAD = 2;  // load return
  localparam int WB_ALU  = 3;  // ALU / jalr link

  localparam int RR_W   = 2;   // round-robin pointer width (covers 4 requesters)
  localparam int DROP_W = 8;   // saturating drop counter width

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the requesters and the arbiter.
// Handshake: a requester raises req[i] with req_addr/req_data slice i and holds
// all three stable until the cycle gnt[i] is high; the transfer happens in that
// cycle, and req[i] may stay high to start another write immediately.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic                 hold;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [RR_W-1:0]      rr_ptr;
  logic [DROP_W-1:0]    drop_cnt;

  modport master (
    output hold, req, req_addr, req_data,
    input  gnt, rf_we, rf_waddr, rf_wdata, rr_ptr, drop_cnt
  );

  modport slave (
    input  hold, req, req_addr, req_data,
    output gnt, rf_we, rf_waddr, rf_wdata, rr_ptr, drop_cnt
  );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester at or after the
// start index, wrapping from the top index back to 0.
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [RR_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0] gnt_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] idx;
  logic          found;

  // Scan requesters in priority order starting at rr_ptr_i; first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(rr_ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant among the result sources, one
// registered register-file write port, and a counter of writes aimed at r0.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic         WB_CLK,
  input logic         reset_n,
  wb_arbiter_if.slave bus
);
  logic [NREQ-1:0]   pick_gnt;
  logic              grant;
  logic [RR_W-1:0]   win_idx;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_data;

  logic              rf_we_q,    rf_we_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
  logic [RR_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt)
  );

  // Grant is suppressed during a stall and while reset is asserted.
  always_comb begin
    bus.gnt = (!reset_n || bus.hold) ? '0 : pick_gnt;
  end

  // Select the winner's index, address and data from the one-hot grant.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.gnt[i]) begin
        win_idx  = RR_W'(i);
        win_addr = bus.req_addr[i*AW +: AW];
        win_data = bus.req_data[i*DW +: DW];
      end
    end
    grant = |bus.gnt;
  end

  // Next state: pointer advance, write stage and r0 drop counting.
  // A write aimed at r0 is consumed without touching the held address/data.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    drop_cnt_d = drop_cnt_q;
    if (grant) begin
      rr_ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + RR_W'(1);
      if (win_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = win_addr;
        rf_wdata_d = win_data;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge WB_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Drive the registered outputs onto the bus.
  always_comb begin
    bus.rf_we    = rf_we_q;
    bus.rf_waddr = rf_waddr_q;
    bus.rf_wdata = rf_wdata_q;
    bus.rr_ptr   = rr_ptr_q;
    bus.drop_cnt = drop_cnt_q;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write-back requesters (index 0 = CP0/mfc0, 1 = mul/mfhi/mflo, 2 = load, 3 = ALU/jalr).
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DW, default 32, register data width.
REQ-004 WB_CLK  in  1  sole clock; one clock, all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 hold  in  1  pipeline stall; blocks new grants while high.
REQ-007 req  in  NREQ  per-requester write request.
REQ-008 req_addr  in  NREQ*AW  packed destination register per requester (slice i = requester i).
REQ-009 req_data  in  NREQ*DW  packed write data per requester.
REQ-010 gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req.
REQ-011 rf_we  out  1  registered register-file write enable.
REQ-012 rf_waddr  out  AW  registered write address.
REQ-013 rf_wdata  out  DW  registered write data.
REQ-014 rr_ptr  out  2  current round-robin start index (debug/visibility).
REQ-015 drop_cnt  out  8  saturating count of grants that targeted register 0.

Function
REQ-016 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when hold=1 or req=0.
REQ-017 Arbitration SHALL be round-robin: search req starting at rr_ptr, wrapping NREQ-1 -> 0; first set bit wins.
REQ-018 On a grant to index i, rr_ptr SHALL become (i+1) mod NREQ at the next edge; with no grant rr_ptr SHALL hold.
REQ-019 Handshake: requester holds req, req_addr, req_data stable until the cycle its gnt is high; transfer occurs in that cycle; req may stay high to issue a back-to-back write.
REQ-020 Latency: grant in cycle N SHALL drive rf_we=1, rf_waddr/rf_wdata = granted slices in cycle N+1, exactly one cycle.
REQ-021 Cycle with no grant SHALL drive rf_we=0 next cycle; rf_waddr/rf_wdata SHALL hold their previous values.
REQ-022 Grant whose req_addr = 0 SHALL be consumed (gnt high, rr_ptr advances) but SHALL produce rf_we=0 and increment drop_cnt, saturating at 255.
REQ-023 Two requesters targeting the same address in consecutive cycles SHALL both be written, in grant order; the later write wins in the register file.
REQ-024 hold asserted SHALL suppress gnt in that cycle only; the output stage SHALL still retire a grant taken in the previous cycle.
REQ-025 Any requester with req held continuously SHALL be granted within NREQ cycles of hold being low (no starvation).
REQ-026 Data path SHALL be pass-through; no width conversion, sign extension or modification of req_data.

Reset
REQ-027 reset_n low SHALL asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, drop_cnt=0.
REQ-028 gnt SHALL be all-zero while reset_n is low.
REQ-029 Reset mid-operation SHALL discard any grant of the current cycle; no write SHALL issue after reset_n rises until a new grant.

Structure
REQ-030 Shared package SHALL hold NREQ/AW/DW defaults, requester index constants (WB_CP0, WB_MUL, WB_LOAD, WB_ALU) and drop_cnt width.
REQ-031 Round-robin selection SHALL be one sub-module rr_pick (inputs req, rr_ptr; output one-hot gnt); the output register stage and counter SHALL reside in wb_arbiter.

Verification
REQ-032 Reset: reset_n=0 with req=4'b1111 -> gnt=0, rf_we=0, rr_ptr=0, drop_cnt=0.
REQ-033 Fairness: req=4'b1111 held 8 cycles, addrs 1..4 -> gnt order 0,1,2,3,0,1,2,3; rf_waddr 1,2,3,4,1,2,3,4 one cycle later.
REQ-034 Wrap: rr_ptr=3, req=4'b1001 -> gnt=4'b1000, then rr_ptr=0, then gnt=4'b0001.
REQ-035 Zero target: req[2]=1, addr 0, data 32'hDEADBEEF -> gnt[2]=1, next cycle rf_we=0, drop_cnt=1; 300 such grants -> drop_cnt=255.
REQ-036 Hold: req[1]=1 with hold=1 for 3 cycles -> gnt=0 throughout; hold=0 -> gnt[1]=1, next cycle rf_we=1 with req_data[1].
REQ-037 Async reset mid-stream: reset_n pulsed low between edges during streaming grants -> outputs clear immediately, no rf_we until first post-reset grant plus one cycle.
